// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - dwell-timed select sweep and sample capture for an 8:1 switch mux
// Define SCAN_DEBOUNCE_EN to debounce the step pushbutton over DB_CYCLES stable cycles.
module mux_scan_ctrl #(
    parameter int unsigned DWELL     = 25_000_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] mask,
    input  logic       mux_in,
    output logic [2:0] sel,
    output logic [7:0] snap,
    output logic       snap_valid,
    output logic       busy
);
    localparam int unsigned   CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_SAMPLE, S_ADVANCE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      sel_q, sel_d;
    logic [7:0]      acc_q, acc_d;
    logic [7:0]      snap_q, snap_d;
    logic            snap_valid_q, snap_valid_d;
    logic [2:0]      next_sel;

    logic [1:0]      sync_q;
    logic            lvl;
    logic            lvl_prev_q;
    logic            step_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            lvl_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], step};
            lvl_prev_q <= lvl;
        end
    end

`ifdef SCAN_DEBOUNCE_EN
    localparam int unsigned    DBW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    logic [DBW-1:0] db_cnt_q;
    logic           db_q;

    // Debounced level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            db_q     <= 1'b0;
        end else if (sync_q[1] == db_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_q <= '0;
            db_q     <= sync_q[1];
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    assign lvl = db_q;
`else
    assign lvl = sync_q[1];

    if (DB_CYCLES == 0) begin : g_db_unused
    end
`endif

    assign step_evt = lvl & ~lvl_prev_q;

    // Nearest enabled channel from start, wrapping; incl selects whether start itself qualifies.
    function automatic logic [2:0] find_enabled(input logic [2:0] start,
                                                input logic [7:0] m,
                                                input logic       incl);
        logic [2:0] r;
        logic [2:0] idx;
        r = start;
        for (int k = 8; k >= 0; k--) begin
            idx = start + 3'(k);
            if (m[idx] && !(incl && k == 8) && !(!incl && k == 0))
                r = idx;
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        acc_d        = acc_q;
        snap_d       = snap_q;
        snap_valid_d = 1'b0;
        next_sel     = find_enabled(sel_q, mask, 1'b0);
        case (state_q)
            S_IDLE: begin
                if (mask != 8'h00 && (run || step_evt)) begin
                    sel_d   = find_enabled(sel_q, mask, 1'b1);
                    cnt_d   = '0;
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                acc_d[sel_q] = mux_in;
                state_d      = S_ADVANCE;
            end
            S_ADVANCE: begin
                // Wrapping back (or staying on a lone channel) closes the sweep.
                if (next_sel <= sel_q) begin
                    snap_d       = acc_q & mask;
                    snap_valid_d = 1'b1;
                    acc_d        = '0;
                end
                sel_d   = next_sel;
                state_d = (run && mask != 8'h00) ? S_DWELL : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sel_q        <= '0;
            acc_q        <= '0;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            acc_q        <= acc_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign sel        = sel_q;
    assign snap       = snap_q;
    assign snap_valid = snap_valid_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed self-checking bench for mux_scan_ctrl
module tb_mux_scan_ctrl;
    localparam int DWELL     = 4;
    localparam int DB_CYCLES = 8;
`ifdef SCAN_DEBOUNCE_EN
    localparam int STEP_LAT  = 11;
    localparam int STEP_HOLD = 12;
    localparam int STEP_GAP  = 20;
`else
    localparam int STEP_LAT  = 3;
    localparam int STEP_HOLD = 2;
    localparam int STEP_GAP  = 2;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       run     = 1'b0;
    logic       step    = 1'b0;
    logic [7:0] mask    = 8'h00;
    logic [7:0] pattern = 8'h00;
    logic       mux_in;
    logic [2:0] sel;
    logic [7:0] snap;
    logic       snap_valid;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    assign mux_in = pattern[sel];

    always #5 clk = ~clk;

    mux_scan_ctrl #(.DWELL(DWELL), .DB_CYCLES(DB_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .step       (step),
        .mask       (mask),
        .mux_in     (mux_in),
        .sel        (sel),
        .snap       (snap),
        .snap_valid (snap_valid),
        .busy       (busy)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; step = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; step = 1'b0; mask = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++; if (sel !== 3'd0) $display("FAIL reset_sel got %0d want 0", sel); else n_pass++;
        n_checks++; if (snap !== 8'h00) $display("FAIL reset_snap got %h want 00", snap); else n_pass++;
        n_checks++; if (snap_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", snap_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        mask = 8'h20; run = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (sel !== 3'd5) $display("FAIL pre_reset_sel got %0d want 5", sel); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL pre_reset_busy got %b want 1", busy); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (sel !== 3'd0) $display("FAIL async_reset_sel got %0d want 0", sel); else n_pass++;
        n_checks++; if (snap !== 8'h00) $display("FAIL async_reset_snap got %h want 00", snap); else n_pass++;
        n_checks++; if (snap_valid !== 1'b0) $display("FAIL async_reset_valid got %b want 0", snap_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL async_reset_busy got %b want 0", busy); else n_pass++;
        @(negedge clk);
        run = 1'b0; mask = 8'h00; rst_n = 1'b1;
    endtask

    task automatic test_auto_full();
        logic [2:0] exp_sel;
        logic       exp_v;
        logic       exp_busy;
        do_reset();
        pattern = 8'hA5;
        for (int i = 0; i <= 98; i++) begin
            @(negedge clk);
            exp_sel  = (i == 0) ? 3'd0 : 3'((i - 1) / 6);
            exp_v    = (i == 49 || i == 97);
            exp_busy = (i >= 1);
            n_checks++; if (sel !== exp_sel) $display("FAIL auto_sel i=%0d got %0d want %0d", i, sel, exp_sel); else n_pass++;
            n_checks++; if (snap_valid !== exp_v) $display("FAIL auto_valid i=%0d got %b want %b", i, snap_valid, exp_v); else n_pass++;
            n_checks++; if (busy !== exp_busy) $display("FAIL auto_busy i=%0d got %b want %b", i, busy, exp_busy); else n_pass++;
            if (i == 48) begin
                n_checks++; if (snap !== 8'h00) $display("FAIL auto_snap_early got %h want 00", snap); else n_pass++;
            end
            if (exp_v) begin
                n_checks++; if (snap !== 8'hA5) $display("FAIL auto_snap i=%0d got %h want a5", i, snap); else n_pass++;
            end
            if (i == 0) begin mask = 8'hFF; run = 1'b1; end
        end
        run = 1'b0;
    endtask

    task automatic test_sparse();
        logic [2:0] exp_sel;
        logic       exp_v;
        logic       exp_busy;
        do_reset();
        pattern = 8'hFF;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (i == 0 || i > 36) exp_sel = (i == 0) ? 3'd0 : 3'd2;
            else exp_sel = ((((i - 1) / 6) % 2) != 0) ? 3'd4 : 3'd2;
            exp_busy = (i >= 1 && i <= 36);
            exp_v    = (i == 13 || i == 25 || i == 37);
            n_checks++; if (sel !== exp_sel) $display("FAIL sparse_sel i=%0d got %0d want %0d", i, sel, exp_sel); else n_pass++;
            n_checks++; if (busy !== exp_busy) $display("FAIL sparse_busy i=%0d got %b want %b", i, busy, exp_busy); else n_pass++;
            n_checks++; if (snap_valid !== exp_v) $display("FAIL sparse_valid i=%0d got %b want %b", i, snap_valid, exp_v); else n_pass++;
            if (exp_v) begin
                n_checks++; if (snap !== 8'h14) $display("FAIL sparse_snap i=%0d got %h want 14", i, snap); else n_pass++;
            end
            if (i == 0) begin mask = 8'h14; run = 1'b1; end
            if (i == 32) run = 1'b0;
        end
    endtask

    task automatic test_mask_zero();
        int   bad_busy;
        int   bad_sel;
        int   bad_v;
        logic exp_v;
        bad_busy = 0; bad_sel = 0; bad_v = 0;
        for (int j = 0; j <= 114; j++) begin
            @(negedge clk);
            if (j <= 100) begin
                if (busy !== 1'b0) bad_busy++;
                if (sel !== 3'd2) bad_sel++;
                if (snap_valid !== 1'b0) bad_v++;
            end else begin
                exp_v = (j == 107 || j == 113);
                n_checks++; if (sel !== 3'd7) $display("FAIL mask80_sel j=%0d got %0d want 7", j, sel); else n_pass++;
                n_checks++; if (busy !== 1'b1) $display("FAIL mask80_busy j=%0d got %b want 1", j, busy); else n_pass++;
                n_checks++; if (snap_valid !== exp_v) $display("FAIL mask80_valid j=%0d got %b want %b", j, snap_valid, exp_v); else n_pass++;
                if (j == 106) begin
                    n_checks++; if (snap !== 8'h14) $display("FAIL mask80_snap_old got %h want 14", snap); else n_pass++;
                end
                if (exp_v) begin
                    n_checks++; if (snap !== 8'h80) $display("FAIL mask80_snap j=%0d got %h want 80", j, snap); else n_pass++;
                end
            end
            if (j == 0) begin mask = 8'h00; run = 1'b1; end
            if (j == 100) mask = 8'h80;
        end
        n_checks++; if (bad_busy !== 0) $display("FAIL mask0_busy bad_cycles=%0d want 0", bad_busy); else n_pass++;
        n_checks++; if (bad_sel !== 0) $display("FAIL mask0_sel_hold bad_cycles=%0d want 0", bad_sel); else n_pass++;
        n_checks++; if (bad_v !== 0) $display("FAIL mask0_valid bad_cycles=%0d want 0", bad_v); else n_pass++;
        run = 1'b0;
    endtask

    task automatic step_scan(input logic [2:0] exp_sel, input logic exp_v);
        int         busy_cnt;
        logic [2:0] nxt;
        busy_cnt = 0;
        nxt = exp_sel + 3'd1;
        @(negedge clk);
        step = 1'b1;
        for (int c = 1; c <= STEP_LAT + 6 + STEP_GAP; c++) begin
            @(negedge clk);
            if (c == STEP_HOLD) step = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (c == STEP_LAT - 1) begin
                n_checks++; if (busy !== 1'b0) $display("FAIL step_early_busy ch=%0d got %b want 0", exp_sel, busy); else n_pass++;
            end
            if (c == STEP_LAT) begin
                n_checks++; if (busy !== 1'b1) $display("FAIL step_latency ch=%0d got busy=%b want 1", exp_sel, busy); else n_pass++;
                n_checks++; if (sel !== exp_sel) $display("FAIL step_sel ch=%0d got %0d want %0d", exp_sel, sel, exp_sel); else n_pass++;
            end
            if (c == STEP_LAT + 6) begin
                n_checks++; if (busy !== 1'b0) $display("FAIL step_done ch=%0d got busy=%b want 0", exp_sel, busy); else n_pass++;
                n_checks++; if (sel !== nxt) $display("FAIL step_next ch=%0d got %0d want %0d", exp_sel, sel, nxt); else n_pass++;
                n_checks++; if (snap_valid !== exp_v) $display("FAIL step_valid ch=%0d got %b want %b", exp_sel, snap_valid, exp_v); else n_pass++;
            end
        end
        n_checks++; if (busy_cnt !== DWELL + 2) $display("FAIL step_one_channel ch=%0d busy_cycles=%0d want %0d", exp_sel, busy_cnt, DWELL + 2); else n_pass++;
    endtask

    task automatic test_step();
        do_reset();
        mask = 8'hFF; pattern = 8'h3C; run = 1'b0;
        for (int k = 0; k < 8; k++) step_scan(3'(k), (k == 7));
        n_checks++; if (snap !== 8'h3C) $display("FAIL step_snap got %h want 3c", snap); else n_pass++;
    endtask

`ifndef SCAN_DEBOUNCE_EN
    task automatic test_step_while_busy();
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        step = 1'b1;
        for (int c = 1; c <= STEP_LAT + 18; c++) begin
            @(negedge clk);
            if (c == 2) step = 1'b0;
            if (c == 4) step = 1'b1;
            if (c == 6) step = 1'b0;
            if (busy === 1'b1) busy_cnt++;
        end
        n_checks++; if (busy_cnt !== DWELL + 2) $display("FAIL busy_step_dropped busy_cycles=%0d want %0d", busy_cnt, DWELL + 2); else n_pass++;
        n_checks++; if (sel !== 3'd1) $display("FAIL busy_step_sel got %0d want 1", sel); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL busy_step_idle got %b want 0", busy); else n_pass++;
    endtask
`else
    task automatic test_debounce_glitch();
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        step = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 5) step = 1'b0;
            if (busy === 1'b1) busy_cnt++;
        end
        n_checks++; if (busy_cnt !== 0) $display("FAIL glitch_busy busy_cycles=%0d want 0", busy_cnt); else n_pass++;
        n_checks++; if (sel !== 3'd0) $display("FAIL glitch_sel got %0d want 0", sel); else n_pass++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_auto_full();
        test_sparse();
        test_mask_zero();
        test_step();
`ifndef SCAN_DEBOUNCE_EN
        test_step_while_busy();
`else
        test_debounce_glitch();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
